// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the pipeline: data width, canonical NOP and default reset PC.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are reserved (tagged with PC) at grant, filled with data
// in response order, and popped from the head once filled. Flush frees every entry.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    reserve,
  input  logic [XLEN-1:0]         reserve_pc,
  input  logic                    fill,
  input  logic [XLEN-1:0]         fill_data,
  input  logic                    pop,
  output logic                    head_filled,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_data,
  output logic [$clog2(DEPTH):0]  reserved_cnt,
  output logic [$clog2(DEPTH):0]  unfilled_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   head_q, tail_q, fptr_q;
  logic [DEPTH-1:0] filled_q;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic [AW-1:0] head_idx, tail_idx, fptr_idx;
  logic          do_reserve, do_fill, do_pop;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign fptr_idx = fptr_q[AW-1:0];

  assign reserved_cnt = tail_q - head_q;
  assign unfilled_cnt = tail_q - fptr_q;

  assign do_reserve  = reserve & (reserved_cnt != DEPTH_P);
  assign do_fill     = fill & (unfilled_cnt != '0);
  assign head_filled = (reserved_cnt != '0) & filled_q[head_idx];
  assign do_pop      = pop & head_filled;

  assign head_pc   = pc_q[head_idx];
  assign head_data = data_q[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      filled_q <= '0;
    end else if (flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      filled_q <= '0;
    end else begin
      if (do_reserve) begin
        tail_q             <= tail_q + PW'(1);
        filled_q[tail_idx] <= 1'b0;
      end
      if (do_fill) begin
        fptr_q             <= fptr_q + PW'(1);
        filled_q[fptr_idx] <= 1'b1;
      end
      if (do_pop) begin
        head_q             <= head_q + PW'(1);
        filled_q[head_idx] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: the filled bits and pointers qualify it.
  always_ff @(posedge clk) begin
    if (do_reserve) pc_q[tail_idx] <= reserve_pc;
    if (do_fill)    data_q[fptr_idx] <= fill_data;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RISC-V instruction-fetch stage: PC, in-order imem requests, response queue and IF/ID register.
// Optional performance counters FETCH_CNT/BUBBLE_CNT when IF_PERF_CNT_EN is defined.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            PCSrc_EX,
  input  logic [XLEN-1:0] PC_Branch_EX,
  input  logic            IF_ID_write,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] INSTRUCTION_ID,
  output logic            VALID_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     FETCH_CNT,
  output logic [31:0]     BUBBLE_CNT
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  // Handshake: a request transfers on a cycle with IMEM_REQ & IMEM_GNT; data returns in
  // request order on IMEM_RVALID, never earlier than the cycle after the grant.
  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   drop_q, drop_d;
  logic [XLEN-1:0] pc_id_q, instr_q;
  logic            valid_q;

  logic            redirect, grant, fill, load_en, pop;
  logic            head_filled;
  logic [XLEN-1:0] head_pc, head_data;
  logic [PW-1:0]   reserved_cnt, unfilled_cnt;

  assign redirect  = PCSrc_EX;
  assign IMEM_REQ  = rst_n & (reserved_cnt != DEPTH_P) & ~redirect;
  assign IMEM_ADDR = pc_q;
  assign grant     = IMEM_REQ & IMEM_GNT;
  assign fill      = IMEM_RVALID & (drop_q == '0);
  assign load_en   = IF_ID_write | ~valid_q;
  assign pop       = load_en & head_filled & ~redirect;

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (redirect),
    .reserve      (grant),
    .reserve_pc   (pc_q),
    .fill         (fill),
    .fill_data    (IMEM_RDATA),
    .pop          (pop),
    .head_filled  (head_filled),
    .head_pc      (head_pc),
    .head_data    (head_data),
    .reserved_cnt (reserved_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

  // A redirect turns every outstanding unfilled request into a response to discard,
  // less the one (if any) that is being consumed by RVALID in the same cycle.
  always_comb begin
    drop_d = drop_q;
    if (redirect) begin
      drop_d = drop_q + unfilled_cnt;
      if (IMEM_RVALID && (drop_d != '0)) drop_d = drop_d - PW'(1);
    end else if (IMEM_RVALID && (drop_q != '0)) begin
      drop_d = drop_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      if (redirect)   pc_q <= word_align(PC_Branch_EX);
      else if (grant) pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_id_q <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (redirect) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_en) begin
      if (head_filled) begin
        pc_id_q <= head_pc;
        instr_q <= head_data;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign PC_ID          = pc_id_q;
  assign INSTRUCTION_ID = instr_q;
  assign VALID_ID       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        bubble_load;

  assign bubble_load = redirect | (load_en & ~head_filled);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (pop)         fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble_load) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FETCH_CNT  = fetch_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`else
  // Counters are not built; the fetch path above is unchanged.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stream-level model of the program-order PC and fetch
// address, checked every cycle, plus hand-computed latency/hold/redirect/wrap expectations.
module tb_if_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        pcsrc, if_id_write;
  logic [31:0] pc_branch;
  logic [31:0] pc_id, instr_id;
  logic        valid_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IMEM_REQ       (imem_req),
    .IMEM_ADDR      (imem_addr),
    .IMEM_GNT       (imem_gnt),
    .IMEM_RVALID    (imem_rvalid),
    .IMEM_RDATA     (imem_rdata),
    .PCSrc_EX       (pcsrc),
    .PC_Branch_EX   (pc_branch),
    .IF_ID_write    (if_id_write),
    .PC_ID          (pc_id),
    .INSTRUCTION_ID (instr_id),
    .VALID_ID       (valid_id)
`ifdef IF_PERF_CNT_EN
    ,
    .FETCH_CNT      (fetch_cnt),
    .BUBBLE_CNT     (bubble_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory: fixed 1- or 2-cycle in-order responder ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  int          mem_lat = 1;
  logic        v1, v2;
  logic [31:0] a1, a2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      v1 <= imem_req & imem_gnt;
      a1 <= imem_addr;
      v2 <= v1;
      a2 <= a1;
    end
  end

  assign imem_rvalid = (mem_lat == 1) ? v1 : v2;
  assign imem_rdata  = mem_word((mem_lat == 1) ? a1 : a2);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: exp_pc is the program-order PC of the next instruction decode must see,
  // exp_fa the next fetch address; both advance by 4 or jump to a redirect target.
  logic [31:0] exp_pc, exp_fa, p_tgt;
  logic        p_redirect, p_consume, p_grant, p_load;
  logic [31:0] exp_fetch, exp_bubble;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {31'b0, valid_id}, 32'd0);
      chk("rst_instr", instr_id, NOP_INSTR);
      chk("rst_pc_id", pc_id, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      exp_pc = RST_PC; exp_fa = RST_PC;
      p_redirect = 0; p_consume = 0; p_grant = 0; p_load = 0; p_tgt = '0;
      exp_fetch = 0; exp_bubble = 0;
    end else begin
      if (p_redirect) begin
        exp_pc = p_tgt; exp_fa = p_tgt; exp_bubble++;
      end else begin
        if (p_consume) exp_pc = exp_pc + 32'd4;
        if (p_grant)   exp_fa = exp_fa + 32'd4;
        if (p_load) begin
          if (valid_id) exp_fetch++;
          else          exp_bubble++;
        end
      end
      if (valid_id) begin
        chk("id_pc_order", pc_id, exp_pc);
        chk("id_instr_data", instr_id, mem_word(pc_id));
      end else begin
        chk("id_nop", instr_id, NOP_INSTR);
      end
      chk("fetch_addr", imem_addr, exp_fa);
      if (pcsrc) chk("req_off_on_redirect", {31'b0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, exp_fetch);
      chk("bubble_cnt", bubble_cnt, exp_bubble);
`endif
      p_redirect = pcsrc;
      p_tgt      = {pc_branch[31:2], 2'b00};
      p_consume  = valid_id & if_id_write;
      p_grant    = imem_req & imem_gnt;
      p_load     = if_id_write | ~valid_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (reset released 1 time unit after an edge).
  task automatic do_reset(input int lat, input logic gnt);
    rst_n = 1'b0; pcsrc = 1'b0; pc_branch = '0; if_id_write = 1'b1; imem_gnt = gnt;
    mem_lat = lat;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    pcsrc = 1'b1; pc_branch = tgt;
    @(negedge clk);
    chk("redir_req_low", {31'b0, imem_req}, 32'd0);
    step();
    pcsrc = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; pcsrc = 1'b0; pc_branch = '0; if_id_write = 1'b1; imem_gnt = 1'b1;

    // 1+2: streaming with 1-cycle memory, then decode stall for 5 cycles at PC_ID=8
    do_reset(1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if_id_write = !(k >= 5 && k <= 9);
      @(negedge clk);
      if (k < 3) chk("t1_latency_valid", {31'b0, valid_id}, 32'd0);
      else if (k == 3) begin
        chk("t1_first_pc", pc_id, 32'h0);
        chk("t1_first_instr", instr_id, 32'hC0DE_0000);
`ifdef IF_PERF_CNT_EN
        chk("t1_fetch_cnt", fetch_cnt, 32'd1);
        chk("t1_bubble_cnt", bubble_cnt, 32'd2);
`endif
      end
      else if (k == 4) chk("t1_second_pc", pc_id, 32'h4);
      else if (k <= 10) chk("t2_hold_pc", pc_id, 32'h8);
      else chk("t2_resume_pc", pc_id, 32'd12 + 32'(k - 11) * 32'd4);
      if (k == 7) begin
        chk("t2_req_full", {31'b0, imem_req}, 32'd0);
        chk("t2_addr_full", imem_addr, 32'd28);
      end
      step();
    end

    // 3: redirect with 1-cycle memory, target low bits masked
    redirect_to(32'h0000_0103);
    @(negedge clk);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    chk("t3_bubble1", {31'b0, valid_id}, 32'd0);
    step();
    @(negedge clk); chk("t3_bubble2", {31'b0, valid_id}, 32'd0); step();
    @(negedge clk); chk("t3_bubble3", {31'b0, valid_id}, 32'd0); step();
    @(negedge clk); chk("t3_target_pc", pc_id, 32'h100); chk("t3_target_valid", {31'b0, valid_id}, 32'd1); step();
    @(negedge clk); chk("t3_next_pc", pc_id, 32'h104); step();

    // 3b: 2-cycle memory so two requests are in flight at the redirect; both must be dropped
    do_reset(2, 1'b1);
    repeat (8) step();
    redirect_to(32'h0000_0203);
    @(negedge clk); chk("t3b_addr", imem_addr, 32'h200);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) chk("t3b_bubble", {31'b0, valid_id}, 32'd0);
      else if (k == 5) chk("t3b_target_pc", pc_id, 32'h200);
      else chk("t3b_next_pc", pc_id, 32'h204);
      step();
      @(negedge clk);
    end
    step();

    // 4: grant withheld for 3 cycles after reset
    do_reset(1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) imem_gnt = 1'b1;
      @(negedge clk);
      if (k < 3) begin
        chk("t4_addr_stable", imem_addr, RST_PC);
        chk("t4_req_held", {31'b0, imem_req}, 32'd1);
      end
      if (k < 6) chk("t4_no_valid", {31'b0, valid_id}, 32'd0);
      else chk("t4_first_pc", pc_id, RST_PC);
      step();
    end

    // 5: asynchronous reset between edges while fetching
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {31'b0, valid_id}, 32'd0);
    chk("t5_async_instr", instr_id, NOP_INSTR);
    chk("t5_async_pc_id", pc_id, 32'd0);
    chk("t5_async_req", {31'b0, imem_req}, 32'd0);
    chk("t5_async_addr", imem_addr, RST_PC);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 3) chk("t5_restart_pc", pc_id, RST_PC);
      if (k == 4) chk("t5_restart_next", pc_id, RST_PC + 32'd4);
      step();
    end

    // 6: PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFF9);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("t6_addr_fff8", imem_addr, 32'hFFFF_FFF8);
      if (k == 2) chk("t6_addr_fffc", imem_addr, 32'hFFFF_FFFC);
      if (k == 3) chk("t6_addr_wrap", imem_addr, 32'h0);
      if (k == 4) chk("t6_pc_fff8", pc_id, 32'hFFFF_FFF8);
      if (k == 5) chk("t6_pc_fffc", pc_id, 32'hFFFF_FFFC);
      if (k == 6) chk("t6_pc_wrap", pc_id, 32'h0);
      step();
    end
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
